openadc_light_axi_slave: RTL and testbench
==========================================

# openadc_light_axi_slave

AXI4-Lite responder exposing four 32-bit read/write control registers to the OpenADC light interface logic. It sits between the processing-system AXI interconnect (or the AXI VIP master in simulation) and the capture datapath. It presents register contents as static outputs and emits a one-cycle pulse for every committed write. It supports one outstanding write and one outstanding read; the write and read channels operate independently.

## Interface
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 4, AXI address width; bits [3:2] select the register, bits [1:0] are ignored.
- REG_RESET, 128'h0, packed reset values; register n is bits [32n+31:32n].

- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bresp  out  2  always 2'b00 (OKAY).
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  always 2'b00.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- regs_o  out  128  current register contents, packed as REG_RESET.
- wr_pulse_o  out  4  one-hot, high for one cycle after register n is written.

## Operation
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
  - W_HAVE_A: address latched; awready=0, wready=1.
  - W_HAVE_D: data and strobe latched; awready=1, wready=0.
  - W_RESP: bvalid=1; awready=0, wready=0.
- Write FSM transitions:
  - W_IDLE, AW and W handshake in the same cycle: commit, go to W_RESP.
  - W_IDLE, only AW handshake: go to W_HAVE_A. Only W handshake: go to W_HAVE_D.
  - W_HAVE_A or W_HAVE_D: on the missing handshake, commit using the latched half plus the live half, go to W_RESP.
  - W_RESP: on bvalid & bready, go to W_IDLE.
- Commit: for each byte b with wstrb[b]=1, reg[addr[3:2]][8b+7:8b] <= wdata[8b+7:8b]. wr_pulse_o[addr[3:2]] is set even if wstrb=0.
- Read FSM states:
  - R_IDLE: arready=1.
  - R_DATA: rvalid=1, arready=0; rdata is held stable.
- Read FSM transitions: R_IDLE to R_DATA on AR handshake, which captures reg[araddr[3:2]] into rdata. R_DATA to R_IDLE on rready.
- Read and write to the same register committing on the same edge: the read returns the pre-write value.

## Timing
- Reset values: awready=wready=arready=0 during reset, all 1 in the first cycle after reset deasserts. bvalid=rvalid=0, rdata=0, bresp=rresp=0, wr_pulse_o=0, regs_o=REG_RESET. FSMs return to W_IDLE and R_IDLE.
- Reset mid-transaction: the transaction is dropped, no response is issued, and no partial commit occurs.
- Write latency: completing handshake at edge k gives regs_o updated after edge k, bvalid=1 and wr_pulse_o high in cycle k+1. bvalid then holds until bready.
- Throughput: back-to-back writes with bready tied high run at 1 write per 2 cycles.
- Read latency: AR handshake at edge k gives rvalid=1 in cycle k+1. Reads with rready tied high also run at 1 per 2 cycles.
- AXI rule: valid is never dependent on ready; bvalid and rvalid never drop without a handshake.

## Structure
- Package openadc_light_pkg holds:
  - register index localparams REG_CTRL=0, REG_CFG=1, REG_TRIG=2, REG_AUX=3
  - NUM_REGS=4
  - RESP_OKAY=2'b00
  - enums for the write and read FSM states.
- Sub-module openadc_light_reg_bank: 4x32 storage with byte-strobe write port, combinational read mux and wr_pulse generation. The top level contains only the AXI FSMs.

## Test plan
- Sequential write/read: write 1, 2, 3, 4 to 0x0, 0x4, 0x8, 0xC, then read all four -> rdata 1, 2, 3, 4; bresp and rresp are 0; wr_pulse_o pulses 0001, 0010, 0100, 1000.
- AW before W: awvalid 3 cycles ahead of wvalid, data 32'hDEADBEEF to 0x8 -> bvalid exactly 1 cycle after the W handshake; regs_o[95:64]=32'hDEADBEEF. Repeat with W first.
- Byte strobes: reg1=32'h11223344, then write 32'hAABBCCDD with wstrb=4'b0101 -> reg1=32'h11BB33DD.
- Backpressure: hold bready=0 and rready=0 for 10 cycles -> bvalid and rvalid stay high, rdata is stable, and awready, wready, arready stay 0.
- Same-edge collision: read 0xC and write 32'h5 to 0xC committing on the same edge, reg3 previously 32'h9 -> rdata=32'h9; a subsequent read returns 32'h5.
- Reset mid-operation: assert reset while in W_HAVE_A and R_DATA -> next cycle all outputs are at reset values and regs_o=REG_RESET; no bvalid follows.

Source files
------------

// File: rtl/openadc_light_pkg.sv
// Shared definitions for the OpenADC light AXI4-Lite register slave.
// Register map indices, response codes and FSM state types.
package openadc_light_pkg;

  localparam int NUM_REGS = 4;

  localparam int REG_CTRL = 0;
  localparam int REG_CFG  = 1;
  localparam int REG_TRIG = 2;
  localparam int REG_AUX  = 3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  function automatic logic [NUM_REGS-1:0] onehot(
    input logic [1:0] idx
  );
    return (NUM_REGS)'(1) << idx;
  endfunction

endpackage

// File: rtl/openadc_light_reg_bank.sv
// 4x32 control register storage with byte-strobe write port,
// combinational read mux and one-cycle write pulses.
module openadc_light_reg_bank
  import openadc_light_pkg::*;
#(
  parameter logic [32*NUM_REGS-1:0] REG_RESET = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [1:0]               waddr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic [1:0]               raddr,
  output logic [31:0]              rdata,
  output logic [32*NUM_REGS-1:0]   regs,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  logic [31:0] mem [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= REG_RESET[32*i +: 32];
      end
      wr_pulse <= '0;
    end else begin
      // Pulse fires on every commit, even with all strobes low
      wr_pulse <= we ? onehot(waddr) : '0;
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) begin
            mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign rdata = mem[raddr];

  always_comb begin
    regs = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs[32*i +: 32] = mem[i];
    end
  end

endmodule

// File: rtl/openadc_light_axi_slave.sv
// AXI4-Lite slave for the OpenADC light control registers.
// Independent single-outstanding write and read FSMs.
module openadc_light_axi_slave
  import openadc_light_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter logic [32*NUM_REGS-1:0] REG_RESET = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [32*NUM_REGS-1:0]  regs_o,
  output logic [NUM_REGS-1:0]     wr_pulse_o
);

  wstate_t     wstate;
  rstate_t     rstate;
  logic [1:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        we;
  logic [1:0]  c_idx;
  logic [31:0] c_data;
  logic [3:0]  c_strb;
  logic [31:0] bank_rdata;
  logic        unused_ok;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  assign s_axi_bresp = RESP_OKAY;
  assign s_axi_rresp = RESP_OKAY;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                       s_axi_awaddr, s_axi_araddr};

  // Commit merges the latched half with the live half
  always_comb begin
    we     = 1'b0;
    c_idx  = s_axi_awaddr[3:2];
    c_data = s_axi_wdata;
    c_strb = s_axi_wstrb;
    unique case (wstate)
      W_IDLE:   we = aw_hs & w_hs;
      W_HAVE_A: begin
        we    = w_hs;
        c_idx = aw_idx;
      end
      W_HAVE_D: begin
        we     = aw_hs;
        c_data = w_data;
        c_strb = w_strb;
      end
      default:  we = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wstate        <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      aw_idx        <= '0;
      w_data        <= '0;
      w_strb        <= '0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wstate        <= W_RESP;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b1;
          end else if (aw_hs) begin
            wstate        <= W_HAVE_A;
            aw_idx        <= s_axi_awaddr[3:2];
            s_axi_awready <= 1'b0;
          end else if (w_hs) begin
            wstate       <= W_HAVE_D;
            w_data       <= s_axi_wdata;
            w_strb       <= s_axi_wstrb;
            s_axi_wready <= 1'b0;
          end else begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        W_HAVE_A: begin
          if (w_hs) begin
            wstate       <= W_RESP;
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
          end
        end
        W_HAVE_D: begin
          if (aw_hs) begin
            wstate        <= W_RESP;
            s_axi_awready <= 1'b0;
            s_axi_bvalid  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            wstate        <= W_IDLE;
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Capture happens before any same-edge commit lands
  always_ff @(posedge clock) begin
    if (reset) begin
      rstate        <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rstate        <= R_DATA;
            s_axi_rdata   <= bank_rdata;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rstate        <= R_IDLE;
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  openadc_light_reg_bank #(
    .REG_RESET(REG_RESET)
  ) u_bank (
    .clock    (clock),
    .reset    (reset),
    .we       (we),
    .waddr    (c_idx),
    .wdata    (c_data),
    .wstrb    (c_strb),
    .raddr    (s_axi_araddr[3:2]),
    .rdata    (bank_rdata),
    .regs     (regs_o),
    .wr_pulse (wr_pulse_o)
  );

endmodule

// File: tb/tb_openadc_light_axi_slave.sv
// Scoreboard bench for openadc_light_axi_slave: random and directed
// AXI4-Lite traffic against an array model of the register file.
module tb_openadc_light_axi_slave;

  logic         clock;
  logic         reset;
  logic [3:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] regs;
  logic [3:0]   pulse;

  openadc_light_axi_slave #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(4),
    .REG_RESET (128'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .regs_o        (regs),
    .wr_pulse_o    (pulse)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model [4];
  logic [31:0] exp_r [$];
  logic [1:0]  exp_b [$];
  logic [3:0]  exp_p [$];

  bit bp_rand = 0;
  bit hold    = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [127:0] packm();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
  endtask

  // B/R ready drivers
  initial begin
    bready = 1;
    rready = 1;
    forever begin
      @(posedge clock);
      #1;
      if (hold) begin
        bready = 0;
        rready = 0;
      end else if (bp_rand) begin
        bready = 1'($urandom_range(1));
        rready = 1'($urandom_range(1));
      end else begin
        bready = 1;
        rready = 1;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queues
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bvalid) begin
          check("aw_w_ready_in_resp", {awready, wready}, 2'b00);
          if (exp_b.size() == 0) begin
            fail_now("b_unexpected", "got bvalid=1, expected none");
          end else begin
            check("bresp", bresp, exp_b[0]);
            if (bready) void'(exp_b.pop_front());
          end
        end
        if (rvalid) begin
          check("ar_ready_in_data", arready, 1'b0);
          check("rresp", rresp, 2'b00);
          if (exp_r.size() == 0) begin
            fail_now("r_unexpected", "got rvalid=1, expected none");
          end else begin
            check("rdata", rdata, exp_r[0]);
            if (rready) void'(exp_r.pop_front());
          end
        end
        if (pulse != 4'b0) begin
          if (exp_p.size() == 0) begin
            fail_now("pulse_unexpected", $sformatf(
              "got %b, expected 0000", pulse));
          end else begin
            check("wr_pulse", pulse, exp_p.pop_front());
          end
        end
      end
    end
  end

  // Called and returns at #1 after a rising edge
  task automatic write_axi(input logic [3:0]  addr,
                           input logic [31:0] data,
                           input logic [3:0]  strb,
                           input int ad,
                           input int wd);
    bit aok;
    bit wok;
    aok = 0;
    wok = 0;
    fork
      begin
        repeat (ad) begin
          @(posedge clock);
          #1;
        end
        awaddr  = addr;
        awvalid = 1;
        for (int t = 0; t < 64 && !aok; t++) begin
          @(negedge clock);
          aok = awready;
          @(posedge clock);
          #1;
        end
        awvalid = 0;
      end
      begin
        repeat (wd) begin
          @(posedge clock);
          #1;
        end
        wdata  = data;
        wstrb  = strb;
        wvalid = 1;
        for (int t = 0; t < 64 && !wok; t++) begin
          @(negedge clock);
          wok = wready;
          @(posedge clock);
          #1;
        end
        wvalid = 0;
      end
    join
    if (!aok || !wok) begin
      fail_now("write_timeout", "got no AW/W handshake, expected one");
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
      end
      exp_p.push_back(4'b0001 << addr[3:2]);
      exp_b.push_back(2'b00);
      @(negedge clock);
      check("b_latency", bvalid, 1'b1);
      check("regs", regs, packm());
      @(posedge clock);
      #1;
    end
  endtask

  task automatic read_axi(input logic [3:0] addr);
    bit ok;
    ok = 0;
    araddr  = addr;
    arvalid = 1;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clock);
      ok = arready;
      if (ok) exp_r.push_back(model[addr[3:2]]);
      @(posedge clock);
      #1;
    end
    arvalid = 0;
    if (!ok) begin
      fail_now("read_timeout", "got no AR handshake, expected one");
    end else begin
      @(negedge clock);
      check("r_latency", rvalid, 1'b1);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_readies", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resp", {bresp, rresp}, 4'h0);
    check("rst_pulse", pulse, 4'h0);
    check("rst_regs", regs, 128'h0);
  endtask

  initial begin
    logic [3:0]  a;
    logic [31:0] d;
    reset   = 1;
    awaddr  = 0;
    awprot  = 0;
    awvalid = 0;
    wdata   = 0;
    wstrb   = 0;
    wvalid  = 0;
    araddr  = 0;
    arprot  = 0;
    arvalid = 0;
    model_reset();

    idle(3);
    @(negedge clock);
    check_reset_outputs();
    @(posedge clock);
    #1;
    reset = 0;
    @(posedge clock);
    @(negedge clock);
    check("ready_after_reset", {awready, wready, arready}, 3'b111);
    @(posedge clock);
    #1;

    // Sequential write then read
    for (int i = 0; i < 4; i++) begin
      write_axi(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    end
    for (int i = 0; i < 4; i++) read_axi(4'(i * 4));
    check("seq_regs", regs,
          {32'h4, 32'h3, 32'h2, 32'h1});

    // AW ahead of W, then W ahead of AW
    write_axi(4'h8, 32'hDEADBEEF, 4'hF, 0, 3);
    check("aw_first", regs[95:64], 32'hDEADBEEF);
    write_axi(4'h8, 32'hCAFEF00D, 4'hF, 3, 0);
    check("w_first", regs[95:64], 32'hCAFEF00D);

    // Byte strobes, including an all-zero strobe
    write_axi(4'h4, 32'h11223344, 4'hF, 0, 0);
    write_axi(4'h5, 32'hAABBCCDD, 4'b0101, 1, 0);
    check("strobe", regs[63:32], 32'h11BB33DD);
    write_axi(4'h6, 32'hFFFFFFFF, 4'b0000, 0, 1);
    check("strobe_none", regs[63:32], 32'h11BB33DD);

    // Randomised traffic with random B/R backpressure
    bp_rand = 1;
    for (int i = 0; i < 60; i++) begin
      a = 4'($urandom_range(15));
      d = $urandom;
      if ($urandom_range(2) == 0) begin
        read_axi(a);
      end else begin
        write_axi(a, d, 4'($urandom_range(15)),
                  $urandom_range(3), $urandom_range(3));
      end
    end
    bp_rand = 0;
    idle(4);

    // Backpressure: responses hold, readies stay low
    hold = 1;
    idle(1);
    fork
      write_axi(4'h0, 32'h0BADF00D, 4'hF, 0, 0);
      read_axi(4'h4);
    join
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("hold_valids", {bvalid, rvalid}, 2'b11);
      check("hold_readies", {awready, wready, arready}, 3'b000);
      @(posedge clock);
      #1;
    end
    hold = 0;
    idle(4);

    // Same-edge read and write of reg3
    write_axi(4'hC, 32'h9, 4'hF, 0, 0);
    idle(3);
    fork
      write_axi(4'hC, 32'h5, 4'hF, 0, 0);
      read_axi(4'hC);
    join
    check("collision_old", rdata, 32'h9);
    idle(2);
    read_axi(4'hC);
    check("collision_new", rdata, 32'h5);
    idle(3);

    // Reset while in W_HAVE_A and R_DATA
    hold = 1;
    idle(1);
    read_axi(4'h4);
    awaddr  = 4'h8;
    awvalid = 1;
    @(negedge clock);
    check("pre_rst_awready", awready, 1'b1);
    @(posedge clock);
    #1;
    awvalid = 0;
    reset   = 1;
    exp_r.delete();
    exp_b.delete();
    exp_p.delete();
    model_reset();
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs();
    @(posedge clock);
    #1;
    reset = 0;
    hold  = 0;
    @(posedge clock);
    @(negedge clock);
    check("ready_after_rst2", {awready, wready, arready}, 3'b111);
    @(posedge clock);
    #1;
    idle(6);
    read_axi(4'h8);
    idle(4);

    check("b_queue_empty", 32'(exp_b.size()), 32'h0);
    check("r_queue_empty", 32'(exp_r.size()), 32'h0);
    check("p_queue_empty", 32'(exp_p.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
